instr_mem_loader: RTL and testbench

Writer side of the instruction memory. Takes a byte stream over a valid/ready handshake and packs it big-endian into 32-bit instruction words. Issues one write per word to the instruction memory's write port, addressed in byte units so that the word index is waddr_o/4. Sits between the host/testbench byte source and the instruction memory, and holds the CPU off via busy_o until the program is loaded.

---
 rtl/instr_mem_loader_pkg.sv | 10 +
 rtl/instr_mem_loader_byte_packer.sv | 34 +++
 rtl/instr_mem_loader.sv | 106 ++++++++++
 tb/tb_instr_mem_loader.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// instr_mem_loader_pkg: shared FSM state encoding and word packing constants
package instr_mem_loader_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// instr_mem_loader_byte_packer: big-endian byte-to-word packer with clear, accept and full/last flags
module instr_mem_loader_byte_packer
  import instr_mem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr,
  input  logic        acc,
  input  logic [7:0]  byte_in,
  input  logic        last,
  output logic [31:0] nxt,
  output logic        fin,
  output logic        partial
);
  logic [31:0] buf_q;
  logic [1:0]  cnt;
  // Insert the incoming byte at its big-endian lane; untouched lanes stay zero for a short final word
  always_comb begin
    nxt = buf_q;
    nxt[{~cnt, 3'b000} +: 8] = byte_in;
  end
  assign fin     = acc && (cnt == 2'(WORD_BYTES - 1) || last);
  assign partial = acc && last && cnt != 2'(WORD_BYTES - 1);
  // Buffer and byte counter; cleared between words so zero-fill is implicit
  always_ff @(posedge clk_i) begin
    if (!rst_i || clr) begin
      buf_q <= '0;
      cnt   <= '0;
    end else if (acc) begin
      buf_q <= nxt;
      cnt   <= cnt + 2'd1;
    end
  end
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: packs a byte stream into 32-bit words and writes them to instruction memory (optional CHECKSUM_EN adds csum_o)
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int IDX_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [7:0]       byte_i,
  input  logic             byte_valid_i,
  input  logic             last_i,
  output logic             byte_ready_o,
  output logic             we_o,
  output logic [31:0]      waddr_o,
  output logic [31:0]      wdata_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [IDX_W-1:0] words_o
`ifdef CHECKSUM_EN
  ,
  output logic [31:0]      csum_o
`endif
);
  state_t      state;
  logic        last_q;
  logic        acc;
  logic        clr;
  logic        fin;
  logic        partial;
  logic [31:0] nxt;
  logic        go;
  assign go  = (state == IDLE || state == DONE) && start_i;
  assign acc = state == LOAD && byte_valid_i && byte_ready_o;
  assign clr = state == WRITE || go;
  instr_mem_loader_byte_packer u_packer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (clr),
    .acc     (acc),
    .byte_in (byte_i),
    .last    (last_i),
    .nxt     (nxt),
    .fin     (fin),
    .partial (partial)
  );
  // Load FSM; words_o doubles as the write index and all outputs are registered
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      last_q       <= 1'b0;
      byte_ready_o <= 1'b0;
      we_o         <= 1'b0;
      waddr_o      <= '0;
      wdata_o      <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      words_o      <= '0;
`ifdef CHECKSUM_EN
      csum_o       <= '0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: if (start_i) begin
          state        <= LOAD;
          byte_ready_o <= 1'b1;
          busy_o       <= 1'b1;
          done_o       <= 1'b0;
          err_o        <= 1'b0;
          words_o      <= '0;
`ifdef CHECKSUM_EN
          csum_o       <= '0;
`endif
        end
        LOAD: if (fin) begin
          state        <= WRITE;
          byte_ready_o <= 1'b0;
          we_o         <= 1'b1;
          waddr_o      <= {{(30-IDX_W){1'b0}}, words_o, 2'b00};
          wdata_o      <= nxt;
          last_q       <= last_i;
          words_o      <= words_o + 1'b1;
          if (partial) err_o <= 1'b1;
        end
        WRITE: begin
          we_o <= 1'b0;
`ifdef CHECKSUM_EN
          csum_o <= csum_o ^ wdata_o;
`endif
          if (last_q || words_o == IDX_W'(DEPTH)) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            if (!last_q) err_o <= 1'b1;
          end else begin
            state        <= LOAD;
            byte_ready_o <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed self-checking bench for instr_mem_loader (CHECKSUM_EN checks csum_o when defined)
module tb_instr_mem_loader;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  byte_i = '0;
  logic        byte_valid_i = 1'b0;
  logic        last_i = 1'b0;
  logic        byte_ready_o, we_o, busy_o, done_o, err_o;
  logic [31:0] waddr_o, wdata_o;
  logic [5:0]  words_o;
`ifdef CHECKSUM_EN
  logic [31:0] csum_o;
`endif
  int total = 0;
  int bad = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  instr_mem_loader dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .last_i       (last_i),
    .byte_ready_o (byte_ready_o),
    .we_o         (we_o),
    .waddr_o      (waddr_o),
    .wdata_o      (wdata_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .words_o      (words_o)
`ifdef CHECKSUM_EN
    ,
    .csum_o       (csum_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Record every write-port strobe cycle
  always @(negedge clk_i) if (we_o) begin
    wa.push_back(waddr_o);
    wd.push_back(wdata_o);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic start();
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    wa.delete();
    wd.delete();
  endtask

  task automatic send(input logic [7:0] b, input logic l, input bit gap);
    byte_i = b;
    last_i = l;
    byte_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (byte_ready_o) break;
    end
    if (!byte_ready_o) chk("ready_timeout", {31'd0, byte_ready_o}, 32'd1);
    @(posedge clk_i); #1;
    byte_valid_i = 1'b0;
    last_i = 1'b0;
    if (gap) begin
      @(posedge clk_i); #1;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (done_o) break;
    end
    chk("done_timeout", {31'd0, done_o}, 32'd1);
  endtask

  task automatic send_two(input bit gap);
    logic [7:0] v[8];
    v = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0A};
    start();
    for (int i = 0; i < 8; i++) send(v[i], i == 7, gap);
    wait_done();
    chk("two_n", wa.size(), 2);
    chk("two_a0", wa[0], 32'h0);
    chk("two_d0", wd[0], 32'h20010005);
    chk("two_a1", wa[1], 32'h4);
    chk("two_d1", wd[1], 32'h0000000A);
    chk("two_flags", {busy_o, done_o, err_o}, 3'b010);
    chk("two_words", words_o, 2);
  endtask

  initial begin
    logic [7:0] v6[6];
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ctl", {byte_ready_o, we_o, busy_o, done_o, err_o, words_o}, 0);
    chk("rst_addr", waddr_o, 0);
    chk("rst_data", wdata_o, 0);
    @(posedge clk_i); #1 rst_i = 1'b1;
    // back-to-back bytes
    send_two(1'b0);
    // valid toggling every other cycle
    send_two(1'b1);
    // partial final word is zero-filled and flagged
    v6 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    start();
    for (int i = 0; i < 6; i++) send(v6[i], i == 5, 1'b0);
    wait_done();
    chk("part_n", wa.size(), 2);
    chk("part_d0", wd[0], 32'hAABBCCDD);
    chk("part_d1", wd[1], 32'h11220000);
    chk("part_flags", {done_o, err_o}, 2'b11);
    chk("part_words", words_o, 2);
    // truncation at DEPTH words
    start();
    for (int i = 0; i < 128; i++) send(8'(i), 1'b0, 1'b0);
    wait_done();
    chk("full_n", wa.size(), 32);
    chk("full_alast", wa[31], 32'd124);
    chk("full_dlast", wd[31], 32'h7C7D7E7F);
    chk("full_d5", wd[5], 32'h14151617);
    chk("full_flags", {done_o, err_o}, 2'b11);
    chk("full_words", words_o, 32);
    byte_valid_i = 1'b1;
    byte_i = 8'h55;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("full_extra_rdy", {31'd0, byte_ready_o}, 0);
    end
    byte_valid_i = 1'b0;
    chk("full_extra_n", wa.size(), 32);
    // reset mid-load
    start();
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    rst_i = 1'b0;
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(negedge clk_i);
    chk("mid_rst_ctl", {byte_ready_o, we_o, busy_o, done_o, err_o, words_o}, 0);
    chk("mid_rst_data", wdata_o, 0);
    chk("mid_rst_n", wa.size(), 0);
    start();
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0);
    send(8'h04, 1'b1, 1'b0);
    wait_done();
    chk("restart_n", wa.size(), 1);
    chk("restart_a0", wa[0], 0);
    chk("restart_d0", wd[0], 32'h01020304);
    chk("restart_flags", {done_o, err_o, words_o}, {2'b10, 6'd1});
`ifdef CHECKSUM_EN
    start();
    send(8'h12, 1'b0, 1'b0);
    send(8'h34, 1'b0, 1'b0);
    send(8'h56, 1'b0, 1'b0);
    send(8'h78, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send(8'h0F, i == 3, 1'b0);
    wait_done();
    chk("csum_done", csum_o, 32'h1D3B5977);
    start();
    @(negedge clk_i);
    chk("csum_clr", csum_o, 0);
`else
    chk("no_csum_busy", {31'd0, busy_o}, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
